// File: rtl/wb2axi4l_pkg.sv
// wb2axi4l_pkg
// Shared types and constants for the Wishbone-classic to AXI4-Lite bridge.
//   wb2axi4l_state_e : bridge FSM states
//   RESP_*           : AXI response encodings
//   resp_is_error()  : anything other than OKAY completes the Wishbone
//                      cycle with ERR (EXOKAY is meaningless on AXI4-Lite)
package wb2axi4l_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR_REQ  = 3'd1,
      WR_RESP = 3'd2,
      RD_REQ  = 3'd3,
      RD_RESP = 3'd4,
      DONE    = 3'd5
   } wb2axi4l_state_e;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   function automatic logic resp_is_error(input logic [1:0] resp);
      return (resp != RESP_OKAY);
   endfunction

endpackage

// File: rtl/wb2axi4l_bridge.sv
// wb2axi4l_bridge
// Wishbone-classic slave to AXI4-Lite master, one outstanding transfer.
// A strobe in IDLE is captured into registers and replayed as a single AXI
// write (AW + W, then B) or read (AR, then R). The Wishbone cycle ends with a
// one-cycle ACK (OKAY) or ERR (any other response). If the initiator drops
// cyc while the AXI side is busy, the AXI transfer still runs to completion
// but no ACK/ERR is returned.
//
// Ports
//   clk_i, rst_i               clock, asynchronous active-high reset
//   wb_adr_i/dat_i/sel_i/we_i  Wishbone request (sampled only in IDLE)
//   wb_cyc_i, wb_stb_i         Wishbone cycle / strobe
//   wb_dat_o                   last read data (held until the next read)
//   wb_ack_o, wb_err_o         one-cycle completion pulses
//   m_axi_*                    AXI4-Lite master channels AW, W, B, AR, R
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for cyc & stb, request captured on acceptance
// WR_REQ  | AW and W valid, each drops on its own handshake
// WR_RESP | bready high, waiting for bvalid
// RD_REQ  | arvalid high, waiting for arready
// RD_RESP | rready high, waiting for rvalid (rdata captured)
// DONE    | ACK/ERR pulse unless the cycle was abandoned
module wb2axi4l_bridge
   import wb2axi4l_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                      clk_i,
   input  logic                      rst_i,

   input  logic [ADDR_WIDTH-1:0]     wb_adr_i,
   input  logic [DATA_WIDTH-1:0]     wb_dat_i,
   input  logic [DATA_WIDTH/8-1:0]   wb_sel_i,
   input  logic                      wb_we_i,
   input  logic                      wb_cyc_i,
   input  logic                      wb_stb_i,
   output logic [DATA_WIDTH-1:0]     wb_dat_o,
   output logic                      wb_ack_o,
   output logic                      wb_err_o,

   output logic [ADDR_WIDTH-1:0]     m_axi_awaddr,
   output logic [2:0]                m_axi_awprot,
   output logic                      m_axi_awvalid,
   input  logic                      m_axi_awready,
   output logic [DATA_WIDTH-1:0]     m_axi_wdata,
   output logic [DATA_WIDTH/8-1:0]   m_axi_wstrb,
   output logic                      m_axi_wvalid,
   input  logic                      m_axi_wready,
   input  logic [1:0]                m_axi_bresp,
   input  logic                      m_axi_bvalid,
   output logic                      m_axi_bready,
   output logic [ADDR_WIDTH-1:0]     m_axi_araddr,
   output logic [2:0]                m_axi_arprot,
   output logic                      m_axi_arvalid,
   input  logic                      m_axi_arready,
   input  logic [DATA_WIDTH-1:0]     m_axi_rdata,
   input  logic [1:0]                m_axi_rresp,
   input  logic                      m_axi_rvalid,
   output logic                      m_axi_rready
);

   localparam int STRB_WIDTH = DATA_WIDTH / 8;

   wb2axi4l_state_e state_q, state_d;

   logic [ADDR_WIDTH-1:0] adr_q;
   logic [DATA_WIDTH-1:0] dat_q;
   logic [STRB_WIDTH-1:0] sel_q;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic [1:0]            resp_q;
   logic                  aw_done_q;
   logic                  w_done_q;
   logic                  abort_q;

   logic wb_req;
   logic aw_hs;
   logic w_hs;

   assign wb_req = wb_cyc_i & wb_stb_i;
   assign aw_hs  = m_axi_awvalid & m_axi_awready;
   assign w_hs   = m_axi_wvalid & m_axi_wready;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (wb_req) begin
               state_d = wb_we_i ? WR_REQ : RD_REQ;
            end
         end
         WR_REQ: begin
            // AW and W may complete in either order or together
            if ((aw_done_q | aw_hs) & (w_done_q | w_hs)) begin
               state_d = WR_RESP;
            end
         end
         WR_RESP: begin
            if (m_axi_bvalid) begin
               state_d = DONE;
            end
         end
         RD_REQ: begin
            if (m_axi_arready) begin
               state_d = RD_RESP;
            end
         end
         RD_RESP: begin
            if (m_axi_rvalid) begin
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      m_axi_awvalid = (state_q == WR_REQ) & ~aw_done_q;
      m_axi_wvalid  = (state_q == WR_REQ) & ~w_done_q;
      m_axi_bready  = (state_q == WR_RESP);
      m_axi_arvalid = (state_q == RD_REQ);
      m_axi_rready  = (state_q == RD_RESP);
      wb_ack_o      = (state_q == DONE) & ~abort_q & ~resp_is_error(resp_q);
      wb_err_o      = (state_q == DONE) & ~abort_q &  resp_is_error(resp_q);
   end

   assign m_axi_awaddr = adr_q;
   assign m_axi_araddr = adr_q;
   assign m_axi_wdata  = dat_q;
   assign m_axi_wstrb  = sel_q;
   assign m_axi_awprot = 3'b000;
   assign m_axi_arprot = 3'b000;
   assign wb_dat_o     = rdata_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         adr_q     <= '0;
         dat_q     <= '0;
         sel_q     <= '0;
         rdata_q   <= '0;
         resp_q    <= RESP_OKAY;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         abort_q   <= 1'b0;
      end else begin
         if (state_q == IDLE) begin
            if (wb_req) begin
               adr_q     <= wb_adr_i;
               dat_q     <= wb_dat_i;
               sel_q     <= wb_sel_i;
               aw_done_q <= 1'b0;
               w_done_q  <= 1'b0;
               abort_q   <= 1'b0;
            end
         end else if (state_q != DONE) begin
            // abandoned cycle: finish on AXI, stay silent on Wishbone
            if (!wb_cyc_i) begin
               abort_q <= 1'b1;
            end
         end

         if (aw_hs) begin
            aw_done_q <= 1'b1;
         end
         if (w_hs) begin
            w_done_q <= 1'b1;
         end

         if ((state_q == WR_RESP) && m_axi_bvalid) begin
            resp_q <= m_axi_bresp;
         end
         if ((state_q == RD_RESP) && m_axi_rvalid) begin
            resp_q  <= m_axi_rresp;
            rdata_q <= m_axi_rdata;
         end
      end
   end

endmodule

// File: tb/tb_wb2axi4l_bridge.sv
// tb_wb2axi4l_bridge
// Directed bench: a table of Wishbone transfers with slave delays/responses
// and expected results, plus hand-written abort and reset sequences.
module tb_wb2axi4l_bridge;
   import wb2axi4l_pkg::*;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [31:0] wb_adr_i;
   logic [31:0] wb_dat_i;
   logic [3:0]  wb_sel_i;
   logic        wb_we_i;
   logic        wb_cyc_i;
   logic        wb_stb_i;
   logic [31:0] wb_dat_o;
   logic        wb_ack_o;
   logic        wb_err_o;
   logic [31:0] m_axi_awaddr;
   logic [2:0]  m_axi_awprot;
   logic        m_axi_awvalid;
   logic        m_axi_awready;
   logic [31:0] m_axi_wdata;
   logic [3:0]  m_axi_wstrb;
   logic        m_axi_wvalid;
   logic        m_axi_wready;
   logic [1:0]  m_axi_bresp;
   logic        m_axi_bvalid;
   logic        m_axi_bready;
   logic [31:0] m_axi_araddr;
   logic [2:0]  m_axi_arprot;
   logic        m_axi_arvalid;
   logic        m_axi_arready;
   logic [31:0] m_axi_rdata;
   logic [1:0]  m_axi_rresp;
   logic        m_axi_rvalid;
   logic        m_axi_rready;

   always #5 clk_i = ~clk_i;

   wb2axi4l_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .wb_adr_i      (wb_adr_i),
      .wb_dat_i      (wb_dat_i),
      .wb_sel_i      (wb_sel_i),
      .wb_we_i       (wb_we_i),
      .wb_cyc_i      (wb_cyc_i),
      .wb_stb_i      (wb_stb_i),
      .wb_dat_o      (wb_dat_o),
      .wb_ack_o      (wb_ack_o),
      .wb_err_o      (wb_err_o),
      .m_axi_awaddr  (m_axi_awaddr),
      .m_axi_awprot  (m_axi_awprot),
      .m_axi_awvalid (m_axi_awvalid),
      .m_axi_awready (m_axi_awready),
      .m_axi_wdata   (m_axi_wdata),
      .m_axi_wstrb   (m_axi_wstrb),
      .m_axi_wvalid  (m_axi_wvalid),
      .m_axi_wready  (m_axi_wready),
      .m_axi_bresp   (m_axi_bresp),
      .m_axi_bvalid  (m_axi_bvalid),
      .m_axi_bready  (m_axi_bready),
      .m_axi_araddr  (m_axi_araddr),
      .m_axi_arprot  (m_axi_arprot),
      .m_axi_arvalid (m_axi_arvalid),
      .m_axi_arready (m_axi_arready),
      .m_axi_rdata   (m_axi_rdata),
      .m_axi_rresp   (m_axi_rresp),
      .m_axi_rvalid  (m_axi_rvalid),
      .m_axi_rready  (m_axi_rready)
   );

   int tests_run    = 0;
   int tests_failed = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // slave configuration
   int          aw_dly, w_dly, ar_dly, b_dly, r_dly;
   logic [1:0]  b_resp_cfg, r_resp_cfg;
   logic [31:0] r_data_cfg;

   // monitor results
   int          aw_cyc, w_cyc, ar_cyc, b_cyc, r_cyc;
   int          ack_cnt, err_cnt, stab_err, b_hs_cnt, r_hs_cnt;
   logic [31:0] seen_awaddr, seen_wdata, seen_araddr;
   logic [3:0]  seen_wstrb;

   // slave model state
   bit          hs_aw, hs_w, hs_ar, hs_b, hs_r;
   bit          aw_got, w_got, ar_got;
   int          aw_w, w_w, ar_w, b_w, r_w;
   logic        pv_aw, pv_w, pv_ar;
   logic [31:0] p_awaddr, p_wdata, p_araddr;
   logic [3:0]  p_wstrb;

   task automatic clear_mon();
      aw_cyc = 0; w_cyc = 0; ar_cyc = 0; b_cyc = 0; r_cyc = 0;
      ack_cnt = 0; err_cnt = 0; stab_err = 0; b_hs_cnt = 0; r_hs_cnt = 0;
      seen_awaddr = 'x; seen_wdata = 'x; seen_araddr = 'x; seen_wstrb = 'x;
   endtask

   // AXI4-Lite slave + protocol monitor, evaluated on the falling edge.
   // hs_* record a handshake that the following rising edge will complete.
   initial begin
      m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
      m_axi_bvalid = 0; m_axi_bresp = 0; m_axi_rvalid = 0; m_axi_rresp = 0; m_axi_rdata = 0;
      hs_aw = 0; hs_w = 0; hs_ar = 0; hs_b = 0; hs_r = 0;
      aw_got = 0; w_got = 0; ar_got = 0;
      aw_w = 0; w_w = 0; ar_w = 0; b_w = 0; r_w = 0;
      pv_aw = 0; pv_w = 0; pv_ar = 0;
      p_awaddr = 0; p_wdata = 0; p_araddr = 0; p_wstrb = 0;
      forever begin
         @(negedge clk_i);
         if (rst_i) begin
            m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
            m_axi_bvalid = 0; m_axi_rvalid = 0;
            hs_aw = 0; hs_w = 0; hs_ar = 0; hs_b = 0; hs_r = 0;
            aw_got = 0; w_got = 0; ar_got = 0;
            aw_w = 0; w_w = 0; ar_w = 0; b_w = 0; r_w = 0;
            pv_aw = 0; pv_w = 0; pv_ar = 0;
            continue;
         end
         if (pv_aw && !hs_aw && (!m_axi_awvalid || m_axi_awaddr !== p_awaddr)) stab_err++;
         if (pv_w && !hs_w && (!m_axi_wvalid || m_axi_wdata !== p_wdata || m_axi_wstrb !== p_wstrb)) stab_err++;
         if (pv_ar && !hs_ar && (!m_axi_arvalid || m_axi_araddr !== p_araddr)) stab_err++;

         if (hs_aw) aw_got = 1;
         if (hs_w)  w_got = 1;
         if (hs_ar) ar_got = 1;
         if (hs_b) begin m_axi_bvalid = 0; aw_got = 0; w_got = 0; b_hs_cnt++; end
         if (hs_r) begin m_axi_rvalid = 0; ar_got = 0; r_hs_cnt++; end

         aw_cyc += int'(m_axi_awvalid);
         w_cyc  += int'(m_axi_wvalid);
         ar_cyc += int'(m_axi_arvalid);
         b_cyc  += int'(m_axi_bready);
         r_cyc  += int'(m_axi_rready);
         ack_cnt += int'(wb_ack_o);
         err_cnt += int'(wb_err_o);

         m_axi_awready = m_axi_awvalid && (aw_w >= aw_dly);
         if (m_axi_awvalid && !m_axi_awready) aw_w++; else aw_w = 0;
         m_axi_wready = m_axi_wvalid && (w_w >= w_dly);
         if (m_axi_wvalid && !m_axi_wready) w_w++; else w_w = 0;
         m_axi_arready = m_axi_arvalid && (ar_w >= ar_dly);
         if (m_axi_arvalid && !m_axi_arready) ar_w++; else ar_w = 0;

         if (m_axi_awvalid && m_axi_awready) seen_awaddr = m_axi_awaddr;
         if (m_axi_wvalid && m_axi_wready) begin seen_wdata = m_axi_wdata; seen_wstrb = m_axi_wstrb; end
         if (m_axi_arvalid && m_axi_arready) seen_araddr = m_axi_araddr;

         if (aw_got && w_got && !m_axi_bvalid) begin
            if (b_w >= b_dly) begin m_axi_bvalid = 1; m_axi_bresp = b_resp_cfg; b_w = 0; end
            else b_w++;
         end
         if (ar_got && !m_axi_rvalid) begin
            if (r_w >= r_dly) begin
               m_axi_rvalid = 1; m_axi_rresp = r_resp_cfg; m_axi_rdata = r_data_cfg; r_w = 0;
            end else r_w++;
         end

         hs_aw = m_axi_awvalid && m_axi_awready;
         hs_w  = m_axi_wvalid && m_axi_wready;
         hs_ar = m_axi_arvalid && m_axi_arready;
         hs_b  = m_axi_bvalid && m_axi_bready;
         hs_r  = m_axi_rvalid && m_axi_rready;
         pv_aw = m_axi_awvalid; p_awaddr = m_axi_awaddr;
         pv_w  = m_axi_wvalid;  p_wdata = m_axi_wdata; p_wstrb = m_axi_wstrb;
         pv_ar = m_axi_arvalid; p_araddr = m_axi_araddr;
      end
   end

   // One Wishbone cycle; lat = falling edges from strobe to ACK/ERR (-1 on timeout).
   task automatic run_wb(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, output int lat);
      clear_mon();
      lat = -1;
      @(negedge clk_i);
      wb_we_i = we; wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = sel;
      wb_cyc_i = 1; wb_stb_i = 1;
      for (int n = 1; n <= 60; n++) begin
         @(negedge clk_i);
         if (wb_ack_o || wb_err_o) begin lat = n; break; end
      end
      wb_cyc_i = 0; wb_stb_i = 0;
      repeat (3) @(negedge clk_i);
   endtask

   typedef struct {
      logic        we;
      logic [31:0] adr;
      logic [31:0] dat;
      logic [3:0]  sel;
      int          aw_dly;
      int          w_dly;
      int          ar_dly;
      int          resp_dly;
      logic [1:0]  resp;
      logic [31:0] rdata;
      int          exp_ack;
      int          exp_err;
      int          exp_lat;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vecs[7];

   initial begin
      int lat;
      vec_t v;

      //            we    adr     dat           sel   aw w ar rd resp         rdata         ack err lat exp_rdata
      vecs[0] = '{1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, RESP_OKAY,   32'h0,        1, 0, 3, 32'h0};
      vecs[1] = '{1'b0, 32'h20, 32'h0,        4'hF, 0, 0, 5, 0, RESP_OKAY,   32'hCAFEF00D, 1, 0, 8, 32'hCAFEF00D};
      vecs[2] = '{1'b1, 32'h30, 32'h12345678, 4'h3, 0, 3, 0, 0, RESP_OKAY,   32'h0,        1, 0, 6, 32'hCAFEF00D};
      vecs[3] = '{1'b0, 32'h44, 32'h0,        4'hF, 0, 0, 0, 0, RESP_SLVERR, 32'hBAD0BAD0, 0, 1, 3, 32'hBAD0BAD0};
      vecs[4] = '{1'b1, 32'h48, 32'hFFFFFFFF, 4'h0, 0, 0, 0, 0, RESP_DECERR, 32'h0,        0, 1, 3, 32'hBAD0BAD0};
      vecs[5] = '{1'b0, 32'h4C, 32'h0,        4'hF, 0, 0, 0, 2, RESP_EXOKAY, 32'h13579BDF, 0, 1, 5, 32'h13579BDF};
      vecs[6] = '{1'b1, 32'h54, 32'h0A0B0C0D, 4'h9, 2, 0, 0, 1, RESP_OKAY,   32'h0,        1, 0, 6, 32'h13579BDF};

      aw_dly = 0; w_dly = 0; ar_dly = 0; b_dly = 0; r_dly = 0;
      b_resp_cfg = RESP_OKAY; r_resp_cfg = RESP_OKAY; r_data_cfg = 0;
      wb_adr_i = 0; wb_dat_i = 0; wb_sel_i = 0; wb_we_i = 0; wb_cyc_i = 0; wb_stb_i = 0;
      clear_mon();

      rst_i = 1;
      repeat (3) @(negedge clk_i);
      check("reset ack", {31'b0, wb_ack_o}, 32'h0);
      check("reset err", {31'b0, wb_err_o}, 32'h0);
      check("reset dat", wb_dat_o, 32'h0);
      check("reset valids", {27'b0, m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}, 32'h0);
      check("reset awaddr", m_axi_awaddr, 32'h0);
      check("reset wstrb", {28'b0, m_axi_wstrb}, 32'h0);
      rst_i = 0;

      for (int i = 0; i < 7; i++) begin
         v = vecs[i];
         aw_dly = v.aw_dly; w_dly = v.w_dly; ar_dly = v.ar_dly;
         b_dly = v.resp_dly; r_dly = v.resp_dly;
         b_resp_cfg = v.resp; r_resp_cfg = v.resp; r_data_cfg = v.rdata;
         run_wb(v.we, v.adr, v.dat, v.sel, lat);
         check($sformatf("v%0d latency", i), lat, v.exp_lat);
         check($sformatf("v%0d ack count", i), ack_cnt, v.exp_ack);
         check($sformatf("v%0d err count", i), err_cnt, v.exp_err);
         check($sformatf("v%0d wb_dat_o", i), wb_dat_o, v.exp_rdata);
         check($sformatf("v%0d stability", i), stab_err, 0);
         if (v.we) begin
            check($sformatf("v%0d awaddr", i), seen_awaddr, v.adr);
            check($sformatf("v%0d wdata", i), seen_wdata, v.dat);
            check($sformatf("v%0d wstrb", i), {28'b0, seen_wstrb}, {28'b0, v.sel});
            // each valid is high for its delay plus the handshake cycle
            check($sformatf("v%0d awvalid cycles", i), aw_cyc, v.aw_dly + 1);
            check($sformatf("v%0d wvalid cycles", i), w_cyc, v.w_dly + 1);
            check($sformatf("v%0d bready cycles", i), b_cyc, v.resp_dly + 1);
         end else begin
            check($sformatf("v%0d araddr", i), seen_araddr, v.adr);
            check($sformatf("v%0d arvalid cycles", i), ar_cyc, v.ar_dly + 1);
            check($sformatf("v%0d rready cycles", i), r_cyc, v.resp_dly + 1);
         end
      end

      // cyc dropped while waiting for B: B still completes, no ACK/ERR
      aw_dly = 0; w_dly = 0; b_dly = 4; b_resp_cfg = RESP_OKAY;
      clear_mon();
      @(negedge clk_i);
      wb_we_i = 1; wb_adr_i = 32'h50; wb_dat_i = 32'h55AA55AA; wb_sel_i = 4'hF;
      wb_cyc_i = 1; wb_stb_i = 1;
      repeat (3) @(negedge clk_i);
      check("abort in WR_RESP", {31'b0, m_axi_bready}, 32'h1);
      wb_cyc_i = 0; wb_stb_i = 0;
      repeat (12) @(negedge clk_i);
      check("abort ack count", ack_cnt, 0);
      check("abort err count", err_cnt, 0);
      check("abort b handshakes", b_hs_cnt, 1);
      check("abort bready cycles", b_cyc, 5);
      b_dly = 0;
      run_wb(1'b1, 32'h58, 32'h01020304, 4'hF, lat);
      check("post-abort latency", lat, 3);
      check("post-abort ack count", ack_cnt, 1);
      check("post-abort awaddr", seen_awaddr, 32'h58);

      // reset while waiting in RD_RESP
      ar_dly = 0; r_dly = 10; r_resp_cfg = RESP_OKAY; r_data_cfg = 32'h77777777;
      clear_mon();
      @(negedge clk_i);
      wb_we_i = 0; wb_adr_i = 32'h8; wb_cyc_i = 1; wb_stb_i = 1;
      repeat (4) @(negedge clk_i);
      check("pre-reset rready", {31'b0, m_axi_rready}, 32'h1);
      #2 rst_i = 1;
      #1;
      check("async reset valids", {27'b0, m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}, 32'h0);
      check("async reset ack/err", {30'b0, wb_ack_o, wb_err_o}, 32'h0);
      check("async reset wb_dat_o", wb_dat_o, 32'h0);
      check("async reset araddr", m_axi_araddr, 32'h0);
      wb_cyc_i = 0; wb_stb_i = 0;
      repeat (2) @(negedge clk_i);
      rst_i = 0;
      r_dly = 0; r_data_cfg = 32'hA5A50004;
      run_wb(1'b0, 32'h4, 32'h0, 4'hF, lat);
      check("post-reset latency", lat, 3);
      check("post-reset ack count", ack_cnt, 1);
      check("post-reset araddr", seen_araddr, 32'h4);
      check("post-reset wb_dat_o", wb_dat_o, 32'hA5A50004);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
